mux_sel_sequencer: RTL and testbench

Sequencer that drives the 2-bit select of the downstream 4:1 channel mux and captures the mux's selected output bit. It sits directly upstream of that mux, in the instruction submodule path. On each accepted command it steps the select through the enabled channels, holding each for a programmable dwell. It samples the returned mux bit at the end of each dwell, then reports completion.

---
 rtl/mux_sel_sequencer_pkg.sv | 28 ++
 rtl/mux_sel_sequencer_dwell_counter.sv | 28 ++
 rtl/mux_sel_sequencer.sv | 154 +++++++++++++++
 tb/tb_mux_sel_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_sel_sequencer_pkg.sv
// Shared types and constants for the 4:1 mux select sequencer.
// Also provides the ascending-order next-enabled-channel search.
package mux_sel_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_DONE  = 2'd2
  } seq_state_e;

  localparam int          NUM_CH   = 4;
  localparam int          CH_W     = 2;
  localparam logic [1:0]  IDLE_SEL = 2'b11;

  // Returns {found, index} of the lowest enabled channel at or above 'from'.
  function automatic logic [CH_W:0] next_enabled(input logic [0:NUM_CH-1] mask,
                                                 input logic [CH_W:0]     from);
    logic [CH_W:0] r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if ((i >= int'(from)) && mask[i]) begin
        r = {1'b1, CH_W'(i)};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_sel_sequencer_dwell_counter.sv
// Loadable DWELL_W-bit down-counter with decrement enable and zero flag.
module dwell_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Load has priority; decrement only requested while nonzero, so no wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mux_sel_sequencer.sv
// Steps the downstream 4:1 mux select through enabled channels and samples its output.
// Optional build macro SEQ_REPEAT_EN turns single-shot operation into a continuous scan.
module mux_sel_sequencer
  import mux_sel_sequencer_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [0:3]         cmd_mask,
  input  logic [DWELL_W-1:0] cmd_dwell,
  output logic [0:1]         sel,
  input  logic               mux_out,
  output logic [0:3]         sample_q,
  output logic               busy,
  output logic               done
);

  // Handshake: a command transfers on a rising edge where cmd_valid and
  // cmd_ready are both high; cmd_ready does not depend on cmd_valid.

  seq_state_e         state, state_n;
  logic [0:3]         mask_q, mask_n;
  logic [DWELL_W-1:0] dwell_q, dwell_n;
  logic [CH_W-1:0]    ch, ch_n;
  logic               clear, capture;
  logic               cnt_load, cnt_dec, cnt_zero;
  logic [DWELL_W-1:0] cnt_load_val;
  logic [DWELL_W-1:0] eff_dwell;
  logic [CH_W:0]      first_cmd, first_lat, next_lat;
  logic               accept;

  assign eff_dwell = (cmd_dwell == '0) ? DWELL_W'(1) : cmd_dwell;
  assign first_cmd = next_enabled(cmd_mask, '0);
  assign first_lat = next_enabled(mask_q, '0);
  assign next_lat  = next_enabled(mask_q, {1'b0, ch} + 1'b1);
  assign accept    = cmd_valid && cmd_ready;

  dwell_counter #(.W(DWELL_W)) u_dwell_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      mask_q  <= '0;
      dwell_q <= DWELL_W'(1);
      ch      <= '0;
    end else begin
      state   <= state_n;
      mask_q  <= mask_n;
      dwell_q <= dwell_n;
      ch      <= ch_n;
    end
  end

  always_comb begin
    state_n      = state;
    mask_n       = mask_q;
    dwell_n      = dwell_q;
    ch_n         = ch;
    clear        = 1'b0;
    capture      = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = dwell_q - 1'b1;
    cnt_dec      = 1'b0;
    cmd_ready    = 1'b0;
    done         = 1'b0;
    unique case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (accept) begin
          mask_n  = cmd_mask;
          dwell_n = eff_dwell;
          clear   = 1'b1;
          if (first_cmd[CH_W]) begin
            ch_n         = first_cmd[CH_W-1:0];
            cnt_load     = 1'b1;
            cnt_load_val = eff_dwell - 1'b1;
            state_n      = ST_DWELL;
          end else begin
            state_n = ST_DONE;
          end
        end
      end
      ST_DWELL: begin
        if (cnt_zero) begin
          capture = 1'b1;
          if (next_lat[CH_W]) begin
            ch_n     = next_lat[CH_W-1:0];
            cnt_load = 1'b1;
          end else begin
            state_n = ST_DONE;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_DONE: begin
        done = 1'b1;
`ifdef SEQ_REPEAT_EN
        cmd_ready = 1'b1;
        if (accept) begin
          mask_n  = cmd_mask;
          dwell_n = eff_dwell;
          clear   = 1'b1;
          if (first_cmd[CH_W]) begin
            ch_n         = first_cmd[CH_W-1:0];
            cnt_load     = 1'b1;
            cnt_load_val = eff_dwell - 1'b1;
            state_n      = ST_DWELL;
          end else begin
            state_n = ST_DONE;
          end
        end else if (first_lat[CH_W]) begin
          // Restart the scan from the lowest enabled channel.
          clear    = 1'b1;
          ch_n     = first_lat[CH_W-1:0];
          cnt_load = 1'b1;
          state_n  = ST_DWELL;
        end else begin
          state_n = ST_IDLE;
        end
`else
        state_n = ST_IDLE;
`endif
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q <= '0;
    end else if (clear) begin
      sample_q <= '0;
    end else if (capture) begin
      sample_q[ch] <= mux_out;
    end
  end

  assign sel  = (state == ST_DWELL) ? ~ch : IDLE_SEL;
  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Directed and randomized checks of mux_sel_sequencer against a trace model of the scan.
// Build with SEQ_REPEAT_EN defined to exercise the continuous-scan mode.
module tb_mux_sel_sequencer;

  localparam int DWELL_W = 8;
`ifdef SEQ_REPEAT_EN
  localparam bit REPEAT = 1'b1;
`else
  localparam bit REPEAT = 1'b0;
`endif

  logic               clk;
  logic               rst_n;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [0:3]         cmd_mask;
  logic [DWELL_W-1:0] cmd_dwell;
  logic [0:1]         sel;
  logic               mux_out;
  logic [0:3]         sample_q;
  logic               busy;
  logic               done;
  logic [0:3]         mux_in;

  int compares = 0;
  int fails    = 0;

  logic [1:0] exp_q[$];

  mux_sel_sequencer #(.DWELL_W(DWELL_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_mask  (cmd_mask),
    .cmd_dwell (cmd_dwell),
    .sel       (sel),
    .mux_out   (mux_out),
    .sample_q  (sample_q),
    .busy      (busy),
    .done      (done)
  );

  // Downstream mux: select value s routes in[3-s].
  assign mux_out = mux_in[~sel];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compares++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: expected select per DWELL cycle, ascending channel order.
  task automatic build_trace(input logic [0:3] m, input int d);
    int eff;
    eff = (d == 0) ? 1 : d;
    exp_q.delete();
    for (int c = 0; c < 4; c++) begin
      if (m[c]) begin
        for (int r = 0; r < eff; r++) exp_q.push_back(2'(3 - c));
      end
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, "_busy"},  32'(busy),      32'd0);
    check({tag, "_done"},  32'(done),      32'd0);
    check({tag, "_sel"},   32'(sel),       32'd3);
  endtask

  task automatic run_cmd(input string tag, input logic [0:3] m, input int d, input logic [0:3] din);
    logic [0:3] exp_s;
    build_trace(m, d);
    exp_s = din & m;
    @(negedge clk);
    check({tag, "_ready_pre"}, 32'(cmd_ready), 32'd1);
    mux_in    = din;
    cmd_mask  = m;
    cmd_dwell = DWELL_W'(d);
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      check({tag, "_sel"},   32'(sel),       32'(exp_q.pop_front()));
      check({tag, "_busy"},  32'(busy),      32'd1);
      check({tag, "_done0"}, 32'(done),      32'd0);
      check({tag, "_rdy0"},  32'(cmd_ready), 32'd0);
    end
    @(negedge clk);
    check({tag, "_done"},     32'(done),      32'd1);
    check({tag, "_sample"},   32'(sample_q),  32'(exp_s));
    check({tag, "_rdy_done"}, 32'(cmd_ready), 32'(REPEAT));
    if (REPEAT && (m != 4'b0000)) begin
      // Stop the continuous scan with a mask-0 command taken in DONE.
      cmd_mask  = 4'b0000;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(negedge clk);
      check({tag, "_stop_done"}, 32'(done),     32'd1);
      check({tag, "_stop_smp"},  32'(sample_q), 32'd0);
    end
    @(negedge clk);
    check_idle({tag, "_after"});
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_mask  = '0;
    cmd_dwell = '0;
    mux_in    = '0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    check("reset_sample", 32'(sample_q), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("reset_rel");

    run_cmd("full",   4'b1111, 1, 4'b1010);
    run_cmd("sparse", 4'b0101, 3, 4'b1111);
    run_cmd("mask0",  4'b0000, 2, 4'b1111);
    run_cmd("dwell0", 4'b1000, 0, 4'b0001);

    // cmd_valid held during DWELL, then reset mid-scan.
    build_trace(4'b1111, 2);
    @(negedge clk);
    mux_in    = 4'b1111;
    cmd_mask  = 4'b1111;
    cmd_dwell = 8'd2;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_mask = 4'b0001;
    cmd_dwell = 8'd1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      check("hold_sel",   32'(sel),       32'(exp_q.pop_front()));
      check("hold_ready", 32'(cmd_ready), 32'd0);
    end
    check("hold_sample", 32'(sample_q), 32'(4'b1100));
    #2 rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    check("async_rst_sample", 32'(sample_q), 32'd0);
    cmd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_cmd("post_rst", 4'b0110, 2, 4'b0100);

`ifdef SEQ_REPEAT_EN
    // Continuous scan: channels 2,3 at dwell 2 give a 5-cycle period.
    @(negedge clk);
    mux_in    = 4'b0011;
    cmd_mask  = 4'b0011;
    cmd_dwell = 8'd2;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int rep = 0; rep < 3; rep++) begin
      build_trace(4'b0011, 2);
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (c == 0) check("rep_clear", 32'(sample_q), 32'd0);
        check("rep_sel",  32'(sel),  32'(exp_q.pop_front()));
        check("rep_done0", 32'(done), 32'd0);
      end
      @(negedge clk);
      check("rep_done",   32'(done),     32'd1);
      check("rep_sample", 32'(sample_q), 32'(4'b0011));
    end
    cmd_mask  = 4'b0000;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("rep_final_done", 32'(done), 32'd1);
    @(negedge clk);
    check_idle("rep_idle");
    @(negedge clk);
    check_idle("rep_idle2");
`endif

    for (int n = 0; n < 40; n++) begin
      logic [0:3] rm;
      logic [0:3] rin;
      int         rd;
      rm  = 4'($urandom_range(0, 15));
      rin = 4'($urandom);
      rd  = $urandom_range(0, 4);
      run_cmd("rand", rm, rd, rin);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
